// File: rtl/add8_err_sweep.sv
// Exhaustive error-characterisation sequencer for one approximate add8-family adder.
// Walks every operand pair, compares against the exact sum, and accumulates EP/MAE/MSE/WCE statistics.
module add8_err_sweep #(
    parameter int W    = 8,
    parameter int HOLD = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [W-1:0]     op_a,
    output logic [W-1:0]     op_b,
    input  logic [W:0]       approx_sum,
    output logic             busy,
    output logic             done,
    output logic [2*W:0]     err_count,
    output logic [3*W:0]     sae,
    output logic [4*W+1:0]   sse,
    output logic [W:0]       wce,
    output logic [W-1:0]     first_err_a,
    output logic [W-1:0]     first_err_b,
    output logic             any_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SWEEP = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t               state_r;
    state_t               state_s;
    logic [3:0]           hold_cnt_r;
    logic                 drain_cnt_r;
    logic                 accept_s;
    logic                 sample_s;
    logic                 last_vec_s;

    logic [W:0]           exact_s;
    logic signed [W+1:0]  err_s;
    logic [W:0]           abs_s;

    logic                 s1_valid_r;
    logic                 s1_flag_r;
    logic [W:0]           s1_abs_r;
    logic [2*W+1:0]       s1_sq_r;
    logic [W-1:0]         s1_a_r;
    logic [W-1:0]         s1_b_r;

    // Magnitude of a signed W+2 bit difference; it always fits in W+1 bits.
    function automatic logic [W:0] abs_f(input logic signed [W+1:0] x);
        logic signed [W+1:0] neg;
        neg = -x;
        if (x[W+1]) begin
            abs_f = neg[W:0];
        end else begin
            abs_f = x[W:0];
        end
    endfunction

    function automatic logic [2*W+1:0] sq_f(input logic [W:0] x);
        sq_f = {{(W+1){1'b0}}, x} * {{(W+1){1'b0}}, x};
    endfunction

    // Next-state logic and per-cycle control strobes.
    always_comb begin
        state_s    = state_r;
        accept_s   = 1'b0;
        sample_s   = 1'b0;
        last_vec_s = (op_a == {W{1'b1}}) && (op_b == {W{1'b1}});
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s  = ST_SWEEP;
                    accept_s = 1'b1;
                end else begin
                    state_s  = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                sample_s = (hold_cnt_r == 4'(HOLD));
                if (sample_s && last_vec_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_SWEEP;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt_r) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Exact reference and signed error of the current vector.
    always_comb begin
        exact_s = {1'b0, op_a} + {1'b0, op_b};
        err_s   = $signed({1'b0, approx_sum}) - $signed({1'b0, exact_s});
        abs_s   = abs_f(err_s);
    end

    // State register, hold/drain counters, operand generator and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            hold_cnt_r  <= 4'd0;
            drain_cnt_r <= 1'b0;
            op_a        <= {W{1'b0}};
            op_b        <= {W{1'b0}};
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state_r     <= state_s;
            done        <= (state_s == ST_DONE);
            busy        <= (state_s == ST_SWEEP) || (state_s == ST_DRAIN);
            drain_cnt_r <= (state_r == ST_DRAIN) ? ~drain_cnt_r : 1'b0;
            if (accept_s) begin
                op_a       <= {W{1'b0}};
                op_b       <= {W{1'b0}};
                hold_cnt_r <= 4'd0;
            end else if (sample_s) begin
                hold_cnt_r <= 4'd0;
                // The final vector stays on the bus; the index never wraps.
                if (!last_vec_s) begin
                    {op_b, op_a} <= {op_b, op_a} + {{(2*W-1){1'b0}}, 1'b1};
                end
            end else if (state_r == ST_SWEEP) begin
                hold_cnt_r <= hold_cnt_r + 4'd1;
            end
        end
    end

    // Pipeline stage 1: register error magnitude, square, flag and operands.
    always_ff @(posedge clk) begin
        if (rst || accept_s) begin
            s1_valid_r <= 1'b0;
            s1_flag_r  <= 1'b0;
            s1_abs_r   <= {(W+1){1'b0}};
            s1_sq_r    <= {(2*W+2){1'b0}};
            s1_a_r     <= {W{1'b0}};
            s1_b_r     <= {W{1'b0}};
        end else begin
            s1_valid_r <= sample_s;
            s1_flag_r  <= (err_s != {(W+2){1'b0}});
            s1_abs_r   <= abs_s;
            s1_sq_r    <= sq_f(abs_s);
            s1_a_r     <= op_a;
            s1_b_r     <= op_b;
        end
    end

    // Pipeline stage 2: accumulate statistics; widths are sized so nothing wraps.
    always_ff @(posedge clk) begin
        if (rst || accept_s) begin
            err_count   <= {(2*W+1){1'b0}};
            sae         <= {(3*W+1){1'b0}};
            sse         <= {(4*W+2){1'b0}};
            wce         <= {(W+1){1'b0}};
            first_err_a <= {W{1'b0}};
            first_err_b <= {W{1'b0}};
            any_err     <= 1'b0;
        end else if (s1_valid_r) begin
            err_count <= err_count + {{(2*W){1'b0}}, s1_flag_r};
            sae       <= sae + {{(2*W){1'b0}}, s1_abs_r};
            sse       <= sse + {{(2*W){1'b0}}, s1_sq_r};
            if (s1_abs_r > wce) begin
                wce <= s1_abs_r;
            end
            if (s1_flag_r && !any_err) begin
                first_err_a <= s1_a_r;
                first_err_b <= s1_b_r;
                any_err     <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_add8_err_sweep.sv
// Self-checking bench: two sweeper instances (W=4/HOLD=0 and W=2/HOLD=3) driven by behavioural adder stubs.
module tb_add8_err_sweep;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, start_a, start_b;
    int   mode_a, mode_b;
    int   rnd_tab [256];
    int   checks, failures;

    logic [3:0]  op_a_a, op_b_a, fa_a, fb_a;
    logic [4:0]  sum_a, wce_a;
    logic        busy_a, done_a, any_a;
    logic [8:0]  cnt_a;
    logic [12:0] sae_a;
    logic [17:0] sse_a;

    logic [1:0]  op_a_b, op_b_b, fa_b, fb_b;
    logic [2:0]  sum_b, wce_b;
    logic        busy_b, done_b, any_b;
    logic [4:0]  cnt_b;
    logic [6:0]  sae_b;
    logic [9:0]  sse_b;

    // Adder stubs: 0 exact, 1 +1 everywhere, 2 wrong only at (3,2), 3 random table, 4 +1 when both LSBs set.
    function automatic int stub_val(input int mode, input int a, input int b);
        case (mode)
            1: return a + b + 1;
            2: return (a == 3 && b == 2) ? a + b + 1 : a + b;
            3: return rnd_tab[b * 16 + a];
            4: return ((a % 2) == 1 && (b % 2) == 1) ? a + b + 1 : a + b;
            default: return a + b;
        endcase
    endfunction

    assign sum_a = 5'(stub_val(mode_a, int'(op_a_a), int'(op_b_a)));
    assign sum_b = 3'(stub_val(mode_b, int'(op_a_b), int'(op_b_b)));

    add8_err_sweep #(.W(4), .HOLD(0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .op_a(op_a_a), .op_b(op_b_a),
        .approx_sum(sum_a), .busy(busy_a), .done(done_a), .err_count(cnt_a),
        .sae(sae_a), .sse(sse_a), .wce(wce_a), .first_err_a(fa_a),
        .first_err_b(fb_a), .any_err(any_a)
    );

    add8_err_sweep #(.W(2), .HOLD(3)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .op_a(op_a_b), .op_b(op_b_b),
        .approx_sum(sum_b), .busy(busy_b), .done(done_b), .err_count(cnt_b),
        .sae(sae_b), .sse(sse_b), .wce(wce_b), .first_err_a(fa_b),
        .first_err_b(fb_b), .any_err(any_b)
    );

    typedef struct {
        longint cnt, sae, sse, wce, fa, fb, any, busy, done, oa, ob;
    } snap_t;

    typedef struct {
        int sel; int mode; int poke;
        longint cnt, sae, sse, wce, fa, fb, any;
        int dcyc;
    } vec_t;

    function automatic snap_t snap(input int sel);
        snap_t s;
        if (sel == 0) begin
            s.cnt = longint'(cnt_a); s.sae = longint'(sae_a); s.sse = longint'(sse_a);
            s.wce = longint'(wce_a); s.fa = longint'(fa_a); s.fb = longint'(fb_a);
            s.any = longint'(any_a); s.busy = longint'(busy_a); s.done = longint'(done_a);
            s.oa = longint'(op_a_a); s.ob = longint'(op_b_a);
        end else begin
            s.cnt = longint'(cnt_b); s.sae = longint'(sae_b); s.sse = longint'(sse_b);
            s.wce = longint'(wce_b); s.fa = longint'(fa_b); s.fb = longint'(fb_b);
            s.any = longint'(any_b); s.busy = longint'(busy_b); s.done = longint'(done_b);
            s.oa = longint'(op_a_b); s.ob = longint'(op_b_b);
        end
        return s;
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel == 0) start_a = v;
        else          start_b = v;
    endtask

    // Reference statistics for the W=4 instance, computed straight from the stub over all 256 pairs.
    task automatic model_a(input int mode, input int poke, output vec_t e);
        e = '{sel: 0, mode: mode, poke: poke, cnt: 0, sae: 0, sse: 0, wce: 0,
              fa: 0, fb: 0, any: 0, dcyc: 259};
        for (int i = 0; i < 256; i++) begin
            int a, b, d, m;
            a = i % 16;
            b = i / 16;
            d = stub_val(mode, a, b) - (a + b);
            m = (d < 0) ? -d : d;
            if (d != 0) begin
                if (e.any == 0) begin
                    e.fa = a; e.fb = b; e.any = 1;
                end
                e.cnt++;
            end
            e.sae += m;
            e.sse += m * m;
            if (m > e.wce) e.wce = m;
        end
    endtask

    task automatic run_row(input vec_t v, input string tag);
        int hold, w, n, budget, done_cyc, pulses, op_bad, k;
        snap_t s, res;
        hold = (v.sel == 0) ? 0 : 3;
        w    = (v.sel == 0) ? 4 : 2;
        n    = 1 << (2 * w);
        budget = (hold + 1) * n + 20;
        done_cyc = -1; pulses = 0; op_bad = 0;
        res = snap(v.sel);
        if (v.sel == 0) mode_a = v.mode;
        else            mode_b = v.mode;
        @(negedge clk);
        set_start(v.sel, 1'b1);
        @(posedge clk);
        #1;
        set_start(v.sel, 1'b0);
        for (int c = 1; c <= budget; c++) begin
            s = snap(v.sel);
            if (c <= (hold + 1) * n) begin
                k = (c - 1) / (hold + 1);
                if (s.oa != longint'(k % (1 << w)) || s.ob != longint'(k / (1 << w)) || s.busy != 1)
                    op_bad++;
            end
            if (s.done == 1) begin
                pulses++;
                if (done_cyc < 0) begin
                    done_cyc = c;
                    res = s;
                end
            end
            if (v.poke != 0 && c == v.poke)     set_start(v.sel, 1'b1);
            if (v.poke != 0 && c == v.poke + 1) set_start(v.sel, 1'b0);
            @(posedge clk);
            #1;
        end
        chk({tag, "_done_cycle"}, done_cyc, v.dcyc);
        chk({tag, "_done_pulses"}, pulses, 1);
        chk({tag, "_op_sequence_errs"}, op_bad, 0);
        chk({tag, "_busy_at_done"}, res.busy, 0);
        chk({tag, "_err_count"}, res.cnt, v.cnt);
        chk({tag, "_sae"}, res.sae, v.sae);
        chk({tag, "_sse"}, res.sse, v.sse);
        chk({tag, "_wce"}, res.wce, v.wce);
        chk({tag, "_first_err_a"}, res.fa, v.fa);
        chk({tag, "_first_err_b"}, res.fb, v.fb);
        chk({tag, "_any_err"}, res.any, v.any);
        s = snap(v.sel);
        chk({tag, "_held_err_count"}, s.cnt, v.cnt);
        chk({tag, "_held_sse"}, s.sse, v.sse);
    endtask

    vec_t  tab [6];
    vec_t  rv;
    snap_t s0;
    int    dpul;

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; mode_a = 0; mode_b = 0;
        for (int i = 0; i < 256; i++) rnd_tab[i] = (i % 16) + (i / 16);

        tab[0] = '{sel: 0, mode: 0, poke: 0,  cnt: 0,   sae: 0,   sse: 0,   wce: 0, fa: 0, fb: 0, any: 0, dcyc: 259};
        tab[1] = '{sel: 0, mode: 1, poke: 0,  cnt: 256, sae: 256, sse: 256, wce: 1, fa: 0, fb: 0, any: 1, dcyc: 259};
        tab[2] = '{sel: 0, mode: 4, poke: 10, cnt: 64,  sae: 64,  sse: 64,  wce: 1, fa: 1, fb: 1, any: 1, dcyc: 259};
        tab[3] = '{sel: 1, mode: 0, poke: 0,  cnt: 0,   sae: 0,   sse: 0,   wce: 0, fa: 0, fb: 0, any: 0, dcyc: 67};
        tab[4] = '{sel: 1, mode: 2, poke: 20, cnt: 1,   sae: 1,   sse: 1,   wce: 1, fa: 3, fb: 2, any: 1, dcyc: 67};
        tab[5] = '{sel: 1, mode: 1, poke: 0,  cnt: 16,  sae: 16,  sse: 16,  wce: 1, fa: 0, fb: 0, any: 1, dcyc: 67};

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            s0 = snap(d);
            chk($sformatf("reset%0d_busy_done", d), s0.busy + s0.done, 0);
            chk($sformatf("reset%0d_ops", d), s0.oa + s0.ob, 0);
            chk($sformatf("reset%0d_stats", d), s0.cnt + s0.sae + s0.sse + s0.wce + s0.fa + s0.fb + s0.any, 0);
        end

        // Reset in the middle of a sweep: everything clears and no done appears.
        mode_a = 1;
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1;
        start_a = 1'b0;
        repeat (98) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        s0 = snap(0);
        chk("midrst_busy_done", s0.busy + s0.done, 0);
        chk("midrst_ops", s0.oa + s0.ob, 0);
        chk("midrst_stats", s0.cnt + s0.sae + s0.sse + s0.wce + s0.fa + s0.fb + s0.any, 0);
        dpul = 0;
        repeat (300) begin
            @(posedge clk);
            #1;
            if (done_a) dpul++;
        end
        chk("midrst_no_done", dpul, 0);

        for (int r = 0; r < 6; r++) run_row(tab[r], $sformatf("row%0d", r));

        // Randomised error tables checked against the arithmetic model.
        for (int t = 0; t < 2; t++) begin
            for (int i = 0; i < 256; i++) begin
                int d, v;
                d = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) - 3 : 0;
                v = (i % 16) + (i / 16) + d;
                if (v < 0)  v = 0;
                if (v > 31) v = 31;
                rnd_tab[i] = v;
            end
            model_a(3, (t == 0) ? 0 : 50, rv);
            run_row(rv, $sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
